cam_capture_ctrl: RTL and testbench

Capture sequencer for the OV7670 camera path, clocked on i_top_clk (50 MHz). It kicks off camera register configuration and supervises it with a timeout. It then gates BRAM pixel writes so that only whole frames are stored, and implements snapshot freeze/resume so the VGA side can display a still frame. It sits between the board buttons and cam_top / mem_bram write-enable, replacing the hard-tied write enable.

---
 rtl/cam_ctrl_pkg.sv | 30 +++
 rtl/cam_capture_ctrl_vsync_sync.sv | 40 ++++
 rtl/cam_capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_ctrl_pkg.sv
// Shared types and defaults for the camera capture sequencer.
// The frame counter is present only when FRAME_CNT_EN is defined.
package cam_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG_REQ  = 3'd1,
        ST_CFG_WAIT = 3'd2,
        ST_SYNC     = 3'd3,
        ST_LIVE     = 3'd4,
        ST_FROZEN   = 3'd5,
        ST_ERROR    = 3'd6
    } state_t;

    // 1 s at 50 MHz
    localparam int DEF_CFG_TIMEOUT = 50_000_000;
    localparam int DEF_START_PULSE = 4;
    localparam int DEF_FCNT_W      = 16;

    // VSYNC is high during blanking; synchroniser flops start there
    localparam logic VS_BLANK = 1'b1;

    // Bits needed to hold a count of 0..n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TCNT_W = cnt_width(DEF_CFG_TIMEOUT);

endpackage

// File: rtl/cam_capture_ctrl_vsync_sync.sv
// Brings raw camera VSYNC into the system clock domain and produces
// one-cycle rise (frame end) and fall (frame start) pulses.
module vsync_sync
    import cam_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_async,
    output logic vs_rise,
    output logic vs_fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;
    logic rise_reg;
    logic fall_reg;

    // Two-flop synchroniser, history flop and registered edge pulses;
    // all history starts at blanking so reset release never looks like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= VS_BLANK;
            sync_reg <= VS_BLANK;
            prev_reg <= VS_BLANK;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            meta_reg <= vsync_async;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
            rise_reg <= sync_reg & ~prev_reg;
            fall_reg <= prev_reg & ~sync_reg;
        end
    end

    assign vs_rise = rise_reg;
    assign vs_fall = fall_reg;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Capture sequencer: starts camera configuration with a timeout guard,
// gates BRAM writes to whole frames and supports snapshot freeze/resume.
// Build option: FRAME_CNT_EN adds the completed-frame counter.
module cam_capture_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int CFG_TIMEOUT = DEF_CFG_TIMEOUT,
    parameter int START_PULSE = DEF_START_PULSE,
    parameter int FCNT_W      = DEF_FCNT_W
) (
    input  logic              i_top_clk,
    input  logic              w_rst_btn_db,
    input  logic              i_start,
    input  logic              i_snap,
    input  logic              i_resume,
    input  logic              i_cam_done,
    input  logic              i_vsync,
    output logic              o_cam_start,
    output logic              o_wr_en,
    output logic              o_frozen,
    output logic              o_busy,
    output logic              o_err,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    localparam int TCNT_W = cnt_width(CFG_TIMEOUT);
    localparam int PCNT_W = cnt_width(START_PULSE);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(CFG_TIMEOUT - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(START_PULSE - 1);

    state_t state_reg, state_next;

    logic [PCNT_W-1:0] pcnt_reg;
    logic [TCNT_W-1:0] tcnt_reg;
    logic              tmo_reg;
    logic              snap_pending_reg;

    logic cam_start_reg, cam_start_next;
    logic wr_en_reg,     wr_en_next;
    logic frozen_reg,    frozen_next;
    logic busy_reg,      busy_next;
    logic err_reg,       err_next;

    logic vs_rise;
    logic vs_fall;

    vsync_sync u_vsync_sync (
        .clk         (i_top_clk),
        .rst_n       (w_rst_btn_db),
        .vsync_async (i_vsync),
        .vs_rise     (vs_rise),
        .vs_fall     (vs_fall)
    );

    // Pulse-width count, timeout count/flag and snapshot request; each
    // clears whenever its owning state is not active
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            pcnt_reg         <= '0;
            tcnt_reg         <= '0;
            tmo_reg          <= 1'b0;
            snap_pending_reg <= 1'b0;
        end else begin
            pcnt_reg <= (state_reg == ST_CFG_REQ) ? pcnt_reg + 1'b1 : '0;
            if (state_reg == ST_CFG_WAIT) begin
                if (tcnt_reg != TCNT_LAST) begin
                    tcnt_reg <= tcnt_reg + 1'b1;
                end
            end else begin
                tcnt_reg <= '0;
            end
            tmo_reg <= (state_reg == ST_CFG_WAIT) && (tcnt_reg == TCNT_LAST);
            if (state_reg == ST_LIVE) begin
                snap_pending_reg <= (snap_pending_reg | i_snap) & ~vs_rise;
            end else begin
                snap_pending_reg <= 1'b0;
            end
        end
    end

    // State register together with the registered outputs
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            state_reg     <= ST_IDLE;
            cam_start_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            frozen_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cam_start_reg <= cam_start_next;
            wr_en_reg     <= wr_en_next;
            frozen_reg    <= frozen_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    // Next-state decision; camera done takes priority over the timeout
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (i_start) state_next = ST_CFG_REQ;
            ST_CFG_REQ:  if (pcnt_reg == PCNT_LAST) state_next = ST_CFG_WAIT;
            ST_CFG_WAIT: begin
                if (i_cam_done) begin
                    state_next = ST_SYNC;
                end else if (tmo_reg) begin
                    state_next = ST_ERROR;
                end
            end
            ST_SYNC:     if (vs_fall) state_next = ST_LIVE;
            ST_LIVE:     if (vs_rise && (snap_pending_reg || i_snap)) state_next = ST_FROZEN;
            ST_FROZEN:   if (i_resume) state_next = ST_SYNC;
            ST_ERROR:    if (i_start) state_next = ST_CFG_REQ;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register in step with it
    always_comb begin
        cam_start_next = (state_next == ST_CFG_REQ);
        wr_en_next     = (state_next == ST_LIVE);
        frozen_next    = (state_next == ST_FROZEN);
        busy_next      = (state_next == ST_CFG_REQ) || (state_next == ST_CFG_WAIT) ||
                         (state_next == ST_SYNC);
        err_next       = (state_next == ST_ERROR);
    end

    assign o_cam_start = cam_start_reg;
    assign o_wr_en     = wr_en_reg;
    assign o_frozen    = frozen_reg;
    assign o_busy      = busy_reg;
    assign o_err       = err_reg;

`ifdef FRAME_CNT_EN
    logic [FCNT_W-1:0] fcnt_reg;

    // Count every frame end seen while writing, including the freezing one
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            fcnt_reg <= '0;
        end else if ((state_reg == ST_LIVE) && vs_rise) begin
            fcnt_reg <= fcnt_reg + 1'b1;
        end
    end

    assign o_frame_cnt = fcnt_reg;
`else
    assign o_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: a per-cycle vector table for the
// bring-up / snapshot / resume flow, then hand sequences for async reset,
// frame counter wrap and configuration timeout with retry.
module tb_cam_capture_ctrl;

    localparam int CFG_TIMEOUT = 100;
    localparam int START_PULSE = 4;
    localparam int FCNT_W      = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic start  = 1'b0;
    logic snap   = 1'b0;
    logic resume = 1'b0;
    logic cam_done = 1'b0;
    logic vsync  = 1'b1;

    logic              cam_start, wr_en, frozen, busy, err;
    logic [FCNT_W-1:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cam_capture_ctrl #(
        .CFG_TIMEOUT (CFG_TIMEOUT),
        .START_PULSE (START_PULSE),
        .FCNT_W      (FCNT_W)
    ) dut (
        .i_top_clk    (clk),
        .w_rst_btn_db (rst_n),
        .i_start      (start),
        .i_snap       (snap),
        .i_resume     (resume),
        .i_cam_done   (cam_done),
        .i_vsync      (vsync),
        .o_cam_start  (cam_start),
        .o_wr_en      (wr_en),
        .o_frozen     (frozen),
        .o_busy       (busy),
        .o_err        (err),
        .o_frame_cnt  (frame_cnt)
    );

    // in  = {start, snap, resume, cam_done, vsync}
    // out = {cam_start, wr_en, frozen, busy, err}
    typedef struct {
        int         rep;
        logic [4:0] in;
        logic [4:0] out;
        int         fc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int rep, logic [4:0] in, logic [4:0] out, int fc);
        vec_t v;
        v.rep = rep; v.in = in; v.out = out; v.fc = fc;
        return v;
    endfunction

    function automatic int exp_fc(int n);
`ifdef FRAME_CNT_EN
        return n % (1 << FCNT_W);
`else
        return n * 0;
`endif
    endfunction

    function automatic logic [8:0] outs_now();
        return {cam_start, wr_en, frozen, busy, err, frame_cnt};
    endfunction

    function automatic logic [8:0] outs_exp(logic [4:0] o, int fc);
        logic [FCNT_W-1:0] f;
        f = FCNT_W'(exp_fc(fc));
        return {o, f};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Drive one cycle of inputs after the edge, then sample just after the next edge
    task automatic apply(logic [4:0] in);
        {start, snap, resume, cam_done, vsync} = in;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check outputs before any clock edge, release
    task automatic async_reset(string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check(name, 32'(outs_now()), 32'd0);
        {start, snap, resume, cam_done} = 4'b0;
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;

        // ---------------- reset values ----------------
        #2 rst_n = 1'b0;
        #1 check("reset_values", 32'(outs_now()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- vector table ----------------
        vt.push_back(mk( 3, 5'b00001, 5'b00000, 0)); // idle
        vt.push_back(mk( 1, 5'b10001, 5'b10010, 0)); // start -> CFG_REQ
        vt.push_back(mk( 3, 5'b00001, 5'b10010, 0)); // pulse cycles 2..4
        vt.push_back(mk(20, 5'b00001, 5'b00010, 0)); // CFG_WAIT
        vt.push_back(mk( 1, 5'b00011, 5'b00010, 0)); // done -> SYNC
        vt.push_back(mk( 5, 5'b00011, 5'b00010, 0)); // blanking
        vt.push_back(mk( 3, 5'b00010, 5'b00010, 0)); // vsync fell, in sync pipe
        vt.push_back(mk( 1, 5'b00010, 5'b01000, 0)); // LIVE
        vt.push_back(mk( 5, 5'b00010, 5'b01000, 0));
        vt.push_back(mk( 1, 5'b00110, 5'b01000, 0)); // resume ignored in LIVE
        vt.push_back(mk( 3, 5'b00011, 5'b01000, 0)); // frame end in pipe
        vt.push_back(mk( 1, 5'b00011, 5'b01000, 1)); // counted, no snapshot
        vt.push_back(mk( 3, 5'b00011, 5'b01000, 1));
        vt.push_back(mk( 4, 5'b00010, 5'b01000, 1)); // next frame
        vt.push_back(mk( 1, 5'b01010, 5'b01000, 1)); // snap mid-frame
        vt.push_back(mk( 3, 5'b00010, 5'b01000, 1));
        vt.push_back(mk( 3, 5'b00011, 5'b01000, 1)); // frame end in pipe
        vt.push_back(mk( 1, 5'b00011, 5'b00100, 2)); // FROZEN, counted
        vt.push_back(mk( 3, 5'b00011, 5'b00100, 2));
        vt.push_back(mk( 1, 5'b01011, 5'b00100, 2)); // snap ignored
        vt.push_back(mk( 1, 5'b10011, 5'b00100, 2)); // start ignored
        vt.push_back(mk( 6, 5'b00010, 5'b00100, 2)); // frames pass uncounted
        vt.push_back(mk( 6, 5'b00011, 5'b00100, 2));
        vt.push_back(mk( 5, 5'b00010, 5'b00100, 2)); // frame in progress
        vt.push_back(mk( 1, 5'b01110, 5'b00010, 2)); // resume+snap -> SYNC
        vt.push_back(mk( 5, 5'b00010, 5'b00010, 2)); // mid-frame not written
        vt.push_back(mk( 4, 5'b00011, 5'b00010, 2)); // rise in SYNC: no count
        vt.push_back(mk( 3, 5'b00011, 5'b00010, 2));
        vt.push_back(mk( 3, 5'b00010, 5'b00010, 2));
        vt.push_back(mk( 1, 5'b00010, 5'b01000, 2)); // LIVE again
        vt.push_back(mk( 3, 5'b00011, 5'b01000, 2));
        vt.push_back(mk( 1, 5'b01011, 5'b00100, 3)); // snap on the rise itself
        vt.push_back(mk( 1, 5'b00101, 5'b00010, 3)); // resume -> SYNC
        vt.push_back(mk( 3, 5'b00010, 5'b00010, 3));
        vt.push_back(mk( 1, 5'b00010, 5'b01000, 3)); // LIVE mid-frame

        for (int i = 0; i < vt.size(); i++) begin
            for (int r = 0; r < vt[i].rep; r++) begin
                apply(vt[i].in);
                check($sformatf("vec[%0d].%0d {cs,we,fz,busy,err,fc}", i, r),
                      32'(outs_now()), 32'(outs_exp(vt[i].out, vt[i].fc)));
            end
        end

        // ---------------- reset mid-frame in LIVE ----------------
        apply(5'b01000);
        check("live_before_reset", 32'(wr_en), 32'd1);
        async_reset("reset_mid_live");
        for (int i = 0; i < 12; i++) begin
            apply((i < 6) ? 5'b00001 : 5'b00000);
            check($sformatf("post_reset_idle.%0d", i), 32'(outs_now()), 32'd0);
        end
        apply(5'b10000);
        check("restart_start", 32'(outs_now()), 32'(outs_exp(5'b10010, 0)));

        // bring up to LIVE and measure the fall-to-write latency
        repeat (8) apply(5'b00011);
        check("sync_wait", 32'(outs_now()), 32'(outs_exp(5'b00010, 0)));
        n = 0;
        while (!wr_en && n < 12) begin
            apply(5'b00000);
            n++;
        end
        check("live_latency", n, 4);

        // ---------------- frame counter across wrap ----------------
        for (int f = 0; f < 17; f++) begin
            repeat (5) apply(5'b00001);
            repeat (5) apply(5'b00000);
            check($sformatf("frame_wrap.%0d", f + 1), 32'(outs_now()),
                  32'(outs_exp(5'b01000, f + 1)));
        end

        // ---------------- timeout and retry ----------------
        async_reset("reset_before_timeout");
        apply(5'b10001);
        w = cam_start ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            apply(5'b00001);
            if (cam_start) w++;
            else break;
        end
        check("start_pulse_width", w, START_PULSE);
        n = 0;
        while (!err && n < 200) begin
            apply(5'b00001);
            n++;
        end
        check("timeout_latency", n, CFG_TIMEOUT + 1);
        check("error_state", 32'(outs_now()), 32'(outs_exp(5'b00001, 0)));
        repeat (3) apply(5'b00001);
        check("error_held", 32'(err), 32'd1);

        apply(5'b10001);
        check("retry_clears_err", 32'(outs_now()), 32'(outs_exp(5'b10010, 0)));
        w = 1;
        for (int i = 0; i < 10; i++) begin
            apply(5'b00001);
            if (cam_start) w++;
            else break;
        end
        check("retry_pulse_width", w, START_PULSE);

        // done arrives in the cycle the counter sits at its last value
        repeat (CFG_TIMEOUT - 1) apply(5'b00001);
        apply(5'b00011);
        check("done_beats_timeout", 32'(outs_now()), 32'(outs_exp(5'b00010, 0)));
        repeat (5) apply(5'b00011);
        check("no_late_err", 32'(outs_now()), 32'(outs_exp(5'b00010, 0)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
